// File: rtl/shot_event_arbiter.sv
// Basketball shot scorer: captures per-hoop shot pulses, arbitrates one hoop at a
// time through IDLE/ARB/ADD/DONE and accumulates a saturating 3-digit BCD score.
module shot_event_arbiter #(
    parameter int SCORE_MAX = 999,
    parameter bit ROT_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        ClrS,
    input  logic        en,
    input  logic [3:0]  req,
    input  logic [3:0]  three,
    output logic [11:0] score_bcd,
    output logic [3:0]  gnt,
    output logic        busy,
    output logic        add_done,
    output logic [3:0]  drop,
    output logic        sat
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [11:0] MAX_BCD = {4'(SCORE_MAX / 100),
                                       4'((SCORE_MAX / 10) % 10),
                                       4'(SCORE_MAX % 10)};

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_pend;
    logic [3:0]  r_val;
    logic [3:0]  r_drop;
    logic [1:0]  r_ptr;
    logic [1:0]  r_win;
    logic        r_pts3;
    logic [11:0] r_score;
    logic        r_sat;

    logic [3:0]  w_req;
    logic        w_any;
    logic [1:0]  w_base;
    logic [1:0]  w_rot_idx [4];
    logic [3:0]  w_rot_pend;
    logic [1:0]  w_win;
    logic        w_win_vld;
    logic [3:0]  w_win_oh;
    logic [3:0]  w_grant;
    logic [3:0]  w_pend_next;
    logic [3:0]  w_val_next;
    logic [3:0]  w_drop_next;

    logic [4:0]  w_dsum [3];
    logic [4:0]  w_dadj [3];
    logic [3:0]  w_carry;
    logic [11:0] w_sum_bcd;
    logic        w_at_max;

    assign w_req = en ? req : 4'b0000;
    assign w_any = |(r_pend | w_req);

    // Search order starts one past the last winner in round-robin mode.
    assign w_base = ROT_EN ? (r_ptr + 2'd1) : 2'd0;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign w_rot_idx[gi]  = w_base + 2'(gi);
            assign w_rot_pend[gi] = r_pend[w_rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        w_win     = w_base;
        w_win_vld = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (w_rot_pend[k]) begin
                w_win     = w_rot_idx[k];
                w_win_vld = 1'b1;
            end
        end
    end

    assign w_win_oh = w_win_vld ? (4'b0001 << w_win) : 4'b0000;
    assign w_grant  = (r_state == ARB) ? w_win_oh : 4'b0000;

    // A request to the hoop being granted re-arms it; any other repeat is lost.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pend
            assign w_pend_next[gi] = w_grant[gi] ? w_req[gi] : (r_pend[gi] | w_req[gi]);
            assign w_val_next[gi]  = (w_req[gi] & (w_grant[gi] | ~r_pend[gi])) ? three[gi]
                                                                             : r_val[gi];
            assign w_drop_next[gi] = w_req[gi] & r_pend[gi] & ~w_grant[gi];
        end
    endgenerate

    assign w_carry[0] = 1'b0;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_bcd
            if (gi == 0) begin : g_lsd
                assign w_dsum[gi] = {1'b0, r_score[3:0]} + (r_pts3 ? 5'd3 : 5'd2);
            end else begin : g_msd
                assign w_dsum[gi] = {1'b0, r_score[4*gi +: 4]} + {4'b0000, w_carry[gi]};
            end
            assign w_dadj[gi]         = w_dsum[gi] - 5'd10;
            assign w_carry[gi + 1]    = (w_dsum[gi] > 5'd9);
            assign w_sum_bcd[4*gi +: 4] = w_carry[gi + 1] ? w_dadj[gi][3:0] : w_dsum[gi][3:0];
        end
    endgenerate

    // Digit-wise BCD compare orders the same as the decimal value.
    assign w_at_max = w_carry[3] | (w_sum_bcd >= MAX_BCD);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (en && w_any) w_state_next = ARB;
            ARB:     w_state_next = ADD;
            ADD:     w_state_next = DONE;
            DONE:    w_state_next = (en && w_any) ? ARB : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge ClrS) begin
        if (ClrS) begin
            r_state <= IDLE;
            r_pend  <= 4'b0000;
            r_val   <= 4'b0000;
            r_drop  <= 4'b0000;
            r_ptr   <= 2'd3;
            r_win   <= 2'd0;
            r_pts3  <= 1'b0;
            r_score <= 12'h000;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
            r_val   <= w_val_next;
            r_drop  <= w_drop_next;
            if (r_state == ARB) begin
                r_win  <= w_win;
                r_pts3 <= r_val[w_win];
            end
            if (r_state == ADD) begin
                if (w_at_max) begin
                    r_score <= MAX_BCD;
                    r_sat   <= 1'b1;
                end else begin
                    r_score <= w_sum_bcd;
                end
            end
            if (r_state == DONE) begin
                r_ptr <= r_win;
            end
        end
    end

    assign gnt       = w_grant;
    assign busy      = (r_state != IDLE);
    assign add_done  = (r_state == DONE);
    assign drop      = r_drop;
    assign score_bcd = r_score;
    assign sat       = r_sat;

endmodule
